// File: rtl/datapath_op_driver.sv
// datapath_op_driver
// Host-side driver for the registered datapath ALU. Commands are taken over a
// valid/ready handshake, registered onto the ALU operand port, and the ALU's
// result is captured two edges later and checked against a golden model.
// Checked results return in command order through a small response FIFO.
// Credits (FIFO occupancy plus both pipeline stages) gate cmd_ready, so the
// push side can never find the FIFO full.
//
// Ports:
//   clk, rst                  rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_a, cmd_b, cmd_op      operands and opcode (00 add, 01 and, 10 xor, 11 pass A)
//   alu_a, alu_b, alu_op      registered operands/opcode to the ALU
//   alu_result, alu_valid     ALU registered result, one cycle after alu_*
//   rsp_valid/rsp_ready       response handshake (FIFO head)
//   rsp_data, rsp_err         head result and its mismatch flag
//   err_count                 saturating count of mismatched results
//   busy                      anything in flight or queued
module datapath_op_driver #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [7:0]       err_count,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   occ_t;
    typedef logic [AW+1:0] cred_t;

    localparam ptr_t  PTR_ONE = ptr_t'(1);
    localparam occ_t  OCC_ONE = occ_t'(1);
    localparam cred_t CRED_MAX = cred_t'(DEPTH);

    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    logic             p1, p2;
    logic [WIDTH-1:0] exp1, exp2;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic             mem_err  [DEPTH];
    ptr_t             wr_ptr, rd_ptr;
    occ_t             occ;

    logic  accept, push, pop, push_err;
    cred_t credits_used;

    // Every accepted-but-not-popped command holds one credit, wherever it is.
    assign credits_used = cred_t'(occ) + cred_t'(p1) + cred_t'(p2);
    assign cmd_ready    = rst & (credits_used < CRED_MAX);
    assign accept       = cmd_valid & cmd_ready;

    assign push      = p2;
    assign push_err  = (alu_result != exp2) | ~alu_valid;
    assign rsp_valid = (occ != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = mem_data[rd_ptr];
    assign rsp_err   = mem_err[rd_ptr];
    assign busy      = p1 | p2 | rsp_valid;

    // Operand registers and expected-value pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            p1     <= 1'b0;
            exp1   <= '0;
            p2     <= 1'b0;
            exp2   <= '0;
        end else begin
            p1   <= accept;
            p2   <= p1;
            exp2 <= exp1;
            if (accept) begin
                alu_a  <= cmd_a;
                alu_b  <= cmd_b;
                alu_op <= cmd_op;
                exp1   <= golden(cmd_a, cmd_b, cmd_op);
            end
        end
    end

    // Response FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= alu_result;
                mem_err[wr_ptr]  <= push_err;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (push && push_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_datapath_op_driver.sv
module tb_datapath_op_driver;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [1:0]       cmd_op = '0;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_valid;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [7:0]       err_count;
    logic             busy;

    // Fault controls, sampled with the command they belong to
    logic bad_in = 1'b0;
    logic inv_in = 1'b0;

    int checks = 0;
    int errors = 0;

    datapath_op_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_valid  (alu_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            2'd0:    return s[15:0];
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Registered ALU neighbour with per-command fault injection
    logic        f_bad = 1'b0, f_inv = 1'b0;
    logic [15:0] alu_q = '0;
    logic        alu_v_q = 1'b1;
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            f_bad <= bad_in;
            f_inv <= inv_in;
        end
        alu_q   <= f_bad ? 16'hDEAD : ref_op(alu_a, alu_b, alu_op);
        alu_v_q <= !f_inv;
    end
    assign alu_result = alu_q;
    assign alu_valid  = alu_v_q;

    // Reference model: every accepted command not yet popped, in order,
    // with the edge number at which it was accepted.
    typedef struct {
        logic [15:0] data;
        logic        err;
        int          e;
    } ent_t;
    ent_t q[$];
    int   ecount = 0;
    int   exp_errcnt = 0;
    int   dut_acc = 0;
    int   dut_pop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: check outputs, then advance the model across the edge.
    task automatic tick();
        logic er, ev, acc, pop;
        ent_t n;
        #1;
        er = rst && (q.size() < DEPTH);
        ev = (q.size() > 0) && (ecount >= q[0].e + 2);
        chk("cmd_ready", cmd_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        chk("busy", busy, q.size() > 0);
        chk("err_count", err_count, exp_errcnt);
        if (ev) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_err", rsp_err, q[0].err);
        end
        acc = cmd_valid && er;
        pop = rsp_ready && ev;
        if (cmd_valid && cmd_ready) dut_acc++;
        if (rsp_valid && rsp_ready) dut_pop++;
        n.data = bad_in ? 16'hDEAD : ref_op(cmd_a, cmd_b, cmd_op);
        n.err  = inv_in || (bad_in && ref_op(cmd_a, cmd_b, cmd_op) != 16'hDEAD);
        @(posedge clk);
        ecount++;
        n.e = ecount;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(n);
        foreach (q[i])
            if (q[i].e + 2 == ecount && q[i].err && exp_errcnt < 255) exp_errcnt++;
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        cmd_a  = a;
        cmd_b  = b;
        cmd_op = op;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_a"}, alu_a, 16'h0);
        chk({tag, "_alu_b"}, alu_b, 16'h0);
        chk({tag, "_alu_op"}, alu_op, 2'h0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_data"}, rsp_data, 16'h0);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk({tag, "_err_count"}, err_count, 8'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    endtask

    logic [15:0] t1_a [4] = '{16'hFFFF, 16'hF0F0, 16'hAAAA, 16'h1234};
    logic [15:0] t1_b [4] = '{16'h0001, 16'h3C3C, 16'h5555, 16'h0000};
    logic [1:0]  t1_op[4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        int base, k, guard;

        // Reset
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Four back-to-back commands with the consumer always ready
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(t1_a[i], t1_b[i], t1_op[i]);
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        repeat (6) tick();

        // Back-pressure: consumer stalled, command offered every cycle
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        base = dut_acc;
        k = 0;
        repeat (9) begin
            set_cmd(16'h0100 + 16'(k), 16'(k), 2'(k));
            tick();
            k = dut_acc - base;
        end
        chk("bp_accepts", dut_acc - base, 4);
        chk("bp_busy", busy, 1'b1);
        chk("bp_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        base = dut_pop;
        repeat (6) tick();
        chk("bp_drained", dut_pop - base, 4);

        // Fault injection: corrupted result, then invalid result
        set_cmd(16'h0001, 16'h0002, 2'd0);
        bad_in = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        bad_in = 1'b0;
        repeat (4) tick();
        chk("fault_bad_errcnt", err_count, 8'd1);
        set_cmd(16'h0005, 16'h0006, 2'd0);
        inv_in = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        inv_in = 1'b0;
        repeat (4) tick();
        chk("fault_inv_errcnt", err_count, 8'd2);

        // Saturation of the mismatch counter
        bad_in = 1'b1;
        cmd_valid = 1'b1;
        repeat (300) begin
            set_cmd(16'($urandom), 16'($urandom), 2'($urandom));
            tick();
        end
        cmd_valid = 1'b0;
        bad_in = 1'b0;
        repeat (6) tick();
        chk("sat_errcnt", err_count, 8'd255);

        // Pointer wrap with random traffic on both sides
        base = dut_acc;
        k = dut_pop;
        guard = 0;
        while ((dut_acc - base) < 10 * DEPTH && guard < 2000) begin
            set_cmd(16'($urandom), 16'($urandom), 2'($urandom));
            cmd_valid = 1'($urandom);
            rsp_ready = 1'($urandom);
            tick();
            guard++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("wrap_accepts", dut_acc - base, 10 * DEPTH);
        chk("wrap_delivered", dut_pop - k, 10 * DEPTH);

        // Reset with two commands in flight and two queued
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(16'h0A00 + 16'(i), 16'h0011, 2'd0);
            tick();
        end
        cmd_valid = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        exp_errcnt = 0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) tick();
        set_cmd(16'h1111, 16'h2222, 2'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
